pm_loader: RTL and testbench
============================

# pm_loader

Program-memory loader for the 4-bit micro: the writer side of the program memory interface the processor reads from. It accepts a host nibble stream over a valid/ready handshake and assembles nibbles into 8-bit instructions. It writes them into program memory from address 0 while holding the micro in reset, then releases it on a verified load. It sits beside `micro`; `hold_micro` is ORed into the micro's reset term.

## Interface

Parameters:
- `ADDR_W`, 8, program memory address width; the length byte 0x00 means 2^ADDR_W instructions.
- `TIMEOUT`, 255, maximum idle cycles between accepted nibbles during a load; 0 disables the timeout.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `rx_nibble`  in  4  host data nibble.
- `rx_valid`  in  1  `rx_nibble` is valid.
- `rx_ready`  out  1  loader accepts a nibble this cycle.
- `load_req`  in  1  single-cycle request to restart loading from RUN or ERR.
- `pm_wr_addr`  out  ADDR_W  program memory write address.
- `pm_wr_data`  out  8  instruction byte to write.
- `pm_wren`  out  1  one-cycle program memory write strobe.
- `hold_micro`  out  1  keeps the micro in reset.
- `load_done`  out  1  load verified; micro running.
- `load_err`  out  1  checksum or timeout failure.

## Operation

- Transfer occurs when `rx_valid && rx_ready`. Nibbles arrive MS first; two nibbles make one byte.
- Stream format:
  - length byte N (0x00 = 2^ADDR_W),
  - N instruction bytes,
  - checksum byte = sum of instruction bytes mod 256.
- States:
  - LEN: hold=1, ready=1. Goes to DATA after the length byte.
  - DATA: ready=1. Each completed byte issues a write; goes to CSUM after the Nth byte.
  - CSUM: ready=1. On the completed byte, goes to RUN on a match, otherwise to ERR.
  - RUN: hold=0, done=1, ready=0. `load_req` goes to LEN.
  - ERR: hold=1, err=1, ready=0. `load_req` goes to LEN.
- `rx_ready` is combinational: 1 exactly in LEN, DATA and CSUM.
- Entering LEN (via reset or `load_req`) performs these clears:
  - write address to 0,
  - nibble phase to high,
  - running sum to 0,
  - count to 0,
  - timeout counter to 0,
  - `done` and `err` to 0.
- Arithmetic:
  - count register is ADDR_W+1 bits wide;
  - sum is 8-bit and wraps;
  - `pm_wr_addr` increments after each write and wraps from 2^ADDR_W−1 to 0 only in the N=2^ADDR_W case (never written past).
- Timeout applies in LEN after the first nibble, in DATA, and in CSUM. The counter clears on each accepted nibble. Reaching TIMEOUT idle cycles goes to ERR.
- `load_req` outside RUN/ERR is ignored. In RUN/ERR, `load_req` and `rx_valid` in the same cycle: `load_req` wins and no nibble is accepted (ready=0).
- A synchronous reset mid-load discards everything and returns to LEN. Program memory contents already written are not cleared.

## Timing

- Reset values:
  - state LEN;
  - `hold_micro`=1;
  - `pm_wren`=0, `pm_wr_addr`=0, `pm_wr_data`=0;
  - `load_done`=0, `load_err`=0;
  - `rx_ready`=1 in the first cycle after reset.
- Write latency: the low nibble of a byte is accepted at edge k. `pm_wren`=1 with registered addr/data during cycle k+1, for one cycle only.
- Addr and data are stable across the negedge at which program memory (clocked on ~clk) samples.
- The host may push one nibble per cycle continuously; no back-pressure occurs inside DATA.
- RUN/ERR registered outputs (`hold_micro`, `load_done`, `load_err`) change one cycle after the final nibble is accepted. The final write's `pm_wren` precedes `hold_micro` falling by ≥1 cycle.
- `load_req` accepted at edge k: `hold_micro`=1 and `rx_ready`=1 from cycle k+1.

## Configuration

- `PM_LOADER_CSUM_EN` defined: CSUM state present; behaviour as above.
- Undefined: no checksum byte. After the Nth instruction byte the loader goes directly to RUN, and `load_err` asserts only on timeout.

## Structure

- Package `pm_loader_pkg`:
  - state enum (LEN, DATA, CSUM, RUN, ERR);
  - nibble-phase constants;
  - default TIMEOUT.
- One sub-module, `pm_loader_timeout`: the idle counter with `clear`, `enable` and `expired` signals, configured by the TIMEOUT parameter (0 ties `expired` low).

## Test plan

- Stream 0,3 | 1,2 | 3,4 | 5,6 | 9,C → writes 0x12@0, 0x34@1, 0x56@2; `hold_micro` 1→0; `load_done`=1; `rx_ready`=0.
- Same stream with checksum 0x9D → `load_err`=1, `hold_micro`=1. Then `load_req` → LEN; a good reload ends in RUN.
- Random `rx_valid` gaps (<TIMEOUT) and stalls in the 3-byte load → identical writes; no nibble is duplicated or dropped.
- Length 0x00 with 256 bytes of value i at address i, plus the correct checksum → 256 writes at addresses 0x00..0xFF, then RUN.
- After the length byte and one data nibble, `rx_valid`=0 for 255 cycles → `load_err` on the 255th idle cycle; no write issued.
- `reset` after 2 of 3 bytes written, then a full 3-byte load → writes restart at addr 0; the sum is computed only over the new bytes.

Source files
------------

// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
package pm_loader_pkg;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_RUN,
        ST_ERR
    } state_e;

    localparam logic PHASE_HI = 1'b0;
    localparam logic PHASE_LO = 1'b1;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/pm_loader_timeout.sv
// Idle-cycle counter: expired pulses on the TIMEOUT-th consecutive enabled cycle without a clear.
module pm_loader_timeout
    import pm_loader_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = ^{clk, reset, clear, enable};
            assign expired       = 1'b0;
        end else begin : g_on
            localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear) begin
                    cnt_d = '0;
                end else if (enable) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // cnt_q holds the number of idle cycles already completed
            assign expired = enable && !clear && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/pm_loader.sv
// Program-memory loader: nibble stream -> instruction writes, holds the micro until loaded.
// Define PM_LOADER_CSUM_EN to require and verify a trailing checksum byte.
module pm_loader
    import pm_loader_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rx_nibble,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic              load_req,
    output logic [ADDR_W-1:0] pm_wr_addr,
    output logic [7:0]        pm_wr_data,
    output logic              pm_wren,
    output logic              hold_micro,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ADDR_W:0] LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

    state_e            state_q, state_d;
    logic              phase_q, phase_d;
    logic [3:0]        hi_nib_q, hi_nib_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        sum_q, sum_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              wren_q, wren_d;
    logic              hold_q, hold_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic       loading, accept, restart;
    logic       tmo_en, tmo_expired, tmo_hit;
    logic [7:0] byte_w;

    assign loading  = state_q inside {ST_LEN, ST_DATA, ST_CSUM};
    assign rx_ready = loading;
    assign accept   = rx_valid && loading;
    assign restart  = load_req && (state_q == ST_RUN || state_q == ST_ERR);
    assign byte_w   = {hi_nib_q, rx_nibble};
    assign tmo_en   = (state_q == ST_DATA) || (state_q == ST_CSUM) ||
                      (state_q == ST_LEN && phase_q == PHASE_LO);

    pm_loader_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .clear  (accept || restart),
        .enable (tmo_en),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        hi_nib_d = hi_nib_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        addr_d   = wren_q ? addr_q + ADDR_W'(1) : addr_q;
        data_d   = data_q;
        wren_d   = 1'b0;
        tmo_hit  = 1'b0;

        if (accept) begin
            if (phase_q == PHASE_HI) begin
                hi_nib_d = rx_nibble;
                phase_d  = PHASE_LO;
            end else begin
                phase_d = PHASE_HI;
                case (state_q)
                    ST_LEN: begin
                        len_d   = (byte_w == 8'h00) ? LEN_FULL : (ADDR_W+1)'(byte_w);
                        state_d = ST_DATA;
                    end
                    ST_DATA: begin
                        data_d = byte_w;
                        wren_d = 1'b1;
                        sum_d  = sum_q + byte_w;
                        cnt_d  = cnt_q + (ADDR_W+1)'(1);
                        if (cnt_d == len_q) begin
`ifdef PM_LOADER_CSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_RUN;
`endif
                        end
                    end
`ifdef PM_LOADER_CSUM_EN
                    ST_CSUM: state_d = (byte_w == sum_q) ? ST_RUN : ST_ERR;
`endif
                    default: ;
                endcase
            end
        end else if (tmo_expired) begin
            state_d = ST_ERR;
            tmo_hit = 1'b1;
        end

        if (restart) begin
            state_d = ST_LEN;
            phase_d = PHASE_HI;
            sum_d   = '0;
            cnt_d   = '0;
            addr_d  = '0;
        end

        // RUN/ERR flags trail the state by one cycle so the last write lands before release;
        // leaving RUN/ERR drops them at once, a timeout raises err immediately.
        done_d = (state_q == ST_RUN) && (state_d == ST_RUN);
        hold_d = !done_d;
        err_d  = ((state_q == ST_ERR) && (state_d == ST_ERR)) || tmo_hit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_LEN;
            phase_q  <= PHASE_HI;
            hi_nib_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            wren_q   <= 1'b0;
            hold_q   <= 1'b1;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            hi_nib_q <= hi_nib_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wren_q   <= wren_d;
            hold_q   <= hold_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign pm_wr_addr = addr_q;
    assign pm_wr_data = data_q;
    assign pm_wren    = wren_q;
    assign hold_micro = hold_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_pm_loader.sv
// Bench for pm_loader: expected-write queue built from the host stream, per-cycle write/flag checks.
module tb_pm_loader;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned TIMEOUT = 255;
`ifdef PM_LOADER_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [3:0]        rx_nibble = '0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic              load_req = 1'b0;
    logic [ADDR_W-1:0] pm_wr_addr;
    logic [7:0]        pm_wr_data;
    logic              pm_wren;
    logic              hold_micro;
    logic              load_done;
    logic              load_err;

    int n_checks = 0;
    int n_fail   = 0;

    int         exp_addr[$];
    int         exp_data[$];
    int         log_addr[$];
    int         log_data[$];
    logic [7:0] stim[$];

    logic hold_prev = 1'b1;
    logic wren_prev = 1'b0;

    always #5 clk = ~clk;

    pm_loader #(
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_nibble (rx_nibble),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .load_req  (load_req),
        .pm_wr_addr(pm_wr_addr),
        .pm_wr_data(pm_wr_data),
        .pm_wren   (pm_wren),
        .hold_micro(hold_micro),
        .load_done (load_done),
        .load_err  (load_err)
    );

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endfunction

    // Compare process: every write must match the next expected (addr, data) pair.
    always @(negedge clk) begin
        if (!reset) begin
            check("hold_vs_done", hold_micro, !load_done);
            if (pm_wren) begin
                check("wren_single_cycle", wren_prev, 1'b0);
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write", pm_wr_addr, pm_wr_data);
                end else begin
                    check("wr_addr", pm_wr_addr, exp_addr.pop_front());
                    check("wr_data", pm_wr_data, exp_data.pop_front());
                end
                log_addr.push_back(int'(pm_wr_addr));
                log_data.push_back(int'(pm_wr_data));
            end
            if (hold_prev && !hold_micro) begin
                check("hold_fall_after_last_wren", pm_wren, 1'b0);
            end
        end
        hold_prev = hold_micro;
        wren_prev = pm_wren;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned pick_gap(input int unsigned maxgap);
        if (maxgap == 0) return 0;
        if ($urandom_range(0, 9) == 0) return $urandom_range(40, 200);
        return $urandom_range(0, maxgap);
    endfunction

    task automatic send_nib(input logic [3:0] n, input int unsigned gap);
        logic        r;
        int unsigned t;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_valid  = 1'b1;
        rx_nibble = n;
        t = 0;
        forever begin
            @(negedge clk);
            r = rx_ready;
            @(posedge clk);
            #1;
            if (r) break;
            t++;
            if (t > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL ready_wait: rx_ready stayed 0, expected 1");
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int unsigned maxgap);
        send_nib(b[7:4], pick_gap(maxgap));
        send_nib(b[3:0], pick_gap(maxgap));
    endtask

    task automatic load(input logic [7:0] len, input int unsigned maxgap, input logic [7:0] csum_delta);
        logic [7:0] sum;
        sum = '0;
        foreach (stim[i]) begin
            exp_addr.push_back(i);
            exp_data.push_back(int'(stim[i]));
            sum = sum + stim[i];
        end
        send_byte(len, maxgap);
        foreach (stim[i]) send_byte(stim[i], maxgap);
        if (CSUM_EN) send_byte(sum + csum_delta, maxgap);
    endtask

    task automatic restart(input string tag);
        load_req  = 1'b1;
        rx_valid  = 1'b1;
        rx_nibble = 4'hF;
        tick();
        load_req = 1'b0;
        rx_valid = 1'b0;
        check({tag, "_hold"}, hold_micro, 1'b1);
        check({tag, "_ready"}, rx_ready, 1'b1);
        check({tag, "_done"}, load_done, 1'b0);
        check({tag, "_err"}, load_err, 1'b0);
    endtask

    task automatic check_run(input string tag);
        repeat (3) tick();
        check({tag, "_done"}, load_done, 1'b1);
        check({tag, "_hold"}, hold_micro, 1'b0);
        check({tag, "_err"}, load_err, 1'b0);
        check({tag, "_ready"}, rx_ready, 1'b0);
        check({tag, "_pending_writes"}, exp_addr.size(), 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_hold"}, hold_micro, 1'b1);
        check({tag, "_wren"}, pm_wren, 1'b0);
        check({tag, "_addr"}, pm_wr_addr, 0);
        check({tag, "_data"}, pm_wr_data, 0);
        check({tag, "_done"}, load_done, 1'b0);
        check({tag, "_err"}, load_err, 1'b0);
        check({tag, "_ready"}, rx_ready, 1'b1);
    endtask

    initial begin
        int early;

        repeat (3) tick();
        reset = 1'b0;
        check_reset_values("rst");

        // Basic 3-byte load
        stim = '{8'h12, 8'h34, 8'h56};
        load(8'h03, 0, 8'h00);
        check_run("basic");
        check("basic_nwrites", log_addr.size(), 3);
        check("basic_w0", {log_addr[0][7:0], log_data[0][7:0]}, 16'h0012);
        check("basic_w1", {log_addr[1][7:0], log_data[1][7:0]}, 16'h0134);
        check("basic_w2", {log_addr[2][7:0], log_data[2][7:0]}, 16'h0256);
        log_addr.delete();
        log_data.delete();

`ifdef PM_LOADER_CSUM_EN
        // Bad checksum 0x9D instead of 0x9C
        restart("req_bad");
        load(8'h03, 0, 8'h01);
        repeat (3) tick();
        check("bad_err", load_err, 1'b1);
        check("bad_hold", hold_micro, 1'b1);
        check("bad_done", load_done, 1'b0);
        check("bad_ready", rx_ready, 1'b0);
        log_addr.delete();
        log_data.delete();
`endif

        restart("req_reload");
        stim = '{8'hA5, 8'h0F, 8'hF0};
        load(8'h03, 0, 8'h00);
        check_run("reload");
        log_addr.delete();
        log_data.delete();

        // Random valid gaps and long stalls
        restart("req_gaps");
        stim = '{8'h12, 8'h34, 8'h56};
        load(8'h03, 6, 8'h00);
        check_run("gaps");
        check("gaps_nwrites", log_addr.size(), 3);
        check("gaps_w1", {log_addr[1][7:0], log_data[1][7:0]}, 16'h0134);
        log_addr.delete();
        log_data.delete();

        // Full-memory load with length byte 0x00
        restart("req_full");
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(8'(i));
        load(8'h00, 0, 8'h00);
        check_run("full");
        check("full_nwrites", log_addr.size(), 256);
        check("full_last_addr", log_addr[255], 255);
        check("full_w200_data", log_data[200], 200);
        log_addr.delete();
        log_data.delete();

        // Idle timeout after length byte and one data nibble
        restart("req_tmo");
        send_byte(8'h03, 0);
        send_nib(4'h7, 0);
        early = 0;
        for (int j = 1; j <= int'(TIMEOUT); j++) begin
            if (load_err !== 1'b0) early++;
            tick();
        end
        check("tmo_err_early", early, 0);
        check("tmo_err", load_err, 1'b1);
        check("tmo_hold", hold_micro, 1'b1);
        check("tmo_ready", rx_ready, 1'b0);
        check("tmo_nwrites", log_addr.size(), 0);

        // Reset in the middle of a load
        restart("req_mid");
        stim = '{8'h11, 8'h22};
        foreach (stim[i]) begin
            exp_addr.push_back(i);
            exp_data.push_back(int'(stim[i]));
        end
        send_byte(8'h03, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (2) tick();
        check("mid_nwrites", log_addr.size(), 2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_values("midrst");
        log_addr.delete();
        log_data.delete();
        stim = '{8'h33, 8'h44, 8'h55};
        load(8'h03, 0, 8'h00);
        check_run("after_rst");
        check("after_rst_w0", {log_addr[0][7:0], log_data[0][7:0]}, 16'h0033);
        check("after_rst_w2", {log_addr[2][7:0], log_data[2][7:0]}, 16'h0255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
